// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared state encodings and mode constants for the serial adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : Start/busy/done operation bus between a requester and the adder.
// Revision : 1.0
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell
// Brief    : Combinational 1-bit full adder.
// Revision : 1.0
// ============================================================================
module fa_cell (
    input  wire logic x,
    input  wire logic y,
    input  wire logic ci,
    output logic      s,
    output logic      co
);
    logic w_p;

    assign w_p = x ^ y;
    assign s   = w_p ^ ci;
    assign co  = (x & y) | (ci & w_p);
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial add/subtract, LSB-first, one bit per clock.
// Revision : 1.0
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_mode;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    fa_cell u_fa (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_accept  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last    = (r_count == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; the concatenation keeps this legal for WIDTH=1.
    assign w_res_nxt = WIDTH'({w_s, r_res_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_mode   <= MODE_ADD;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~borrow; the borrow-out is the inverted carry.
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? ~bus.cin : bus.cin;
            r_mode  <= bus.sub ? MODE_SUB : MODE_ADD;
            r_count <= '0;
        end else if (r_state == ST_RUN) begin
            r_res_sr <= w_res_nxt;
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_co;
            r_count  <= r_count + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= (r_mode == MODE_SUB) ? ~w_co : w_co;
            end
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds).
// Revision : 1.0
// ============================================================================
module tb_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] last_sum;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, not a bit-serial walk.
    function automatic void ref_op(input int w, input bit s, input longint unsigned a,
                                   input longint unsigned b, input bit c,
                                   output longint unsigned sum, output bit co);
        longint unsigned mask;
        longint unsigned full;
        mask = (64'd1 << w) - 64'd1;
        if (!s) begin
            full = a + b + longint'(c);
            sum  = full & mask;
            co   = ((full >> w) & 64'd1) != 0;
        end else begin
            sum = (a - b - longint'(c)) & mask;
            co  = a < (b + longint'(c));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit s, input logic [7:0] a, input logic [7:0] b, input bit c);
        bus8.sub   = s;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.sub   = 1'($urandom);
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    task automatic wait_done(input logic [7:0] old_sum, input int exp_n);
        int n;
        n = 0;
        while (bus8.done !== 1'b1 && n < 100) begin
            check("busy_in_run", 64'(bus8.busy), 64'd1);
            check("sum_held", 64'(bus8.sum), 64'(old_sum));
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(exp_n));
        check("busy_at_done", 64'(bus8.busy), 64'd0);
    endtask

    task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b, input bit c);
        longint unsigned es;
        bit              ec;
        ref_op(8, s, 64'(a), 64'(b), c, es, ec);
        launch(s, a, b, c);
        wait_done(last_sum, 8);
        check("sum", 64'(bus8.sum), es);
        check("cout", 64'(bus8.cout), 64'(ec));
        last_sum = bus8.sum;
        tick();
        check("done_pulse_end", 64'(bus8.done), 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus8.done === 1'b1) nd++;
        end
    endtask

    initial begin
        int              nd;
        longint unsigned es;
        bit              ec;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_done", 64'(bus8.done), 64'd0);
        check("rst_sum", 64'(bus8.sum), 64'd0);
        check("rst_cout", 64'(bus8.cout), 64'd0);
        check("rst_w1_sum", 64'(bus1.sum), 64'd0);
        rst = 1'b0;
        last_sum = 8'h00;
        tick();

        // Directed arithmetic cases
        do_op(1'b0, 8'h0F, 8'h01, 1'b0);
        check("t1_sum", 64'(bus8.sum), 64'h10);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0);
        check("t2_cout", 64'(bus8.cout), 64'd1);
        do_op(1'b0, 8'h00, 8'h00, 1'b1);
        check("t2b_sum", 64'(bus8.sum), 64'h01);
        do_op(1'b1, 8'h05, 8'h07, 1'b0);
        check("t3_sum", 64'(bus8.sum), 64'hFE);
        check("t3_cout", 64'(bus8.cout), 64'd1);
        do_op(1'b1, 8'h07, 8'h05, 1'b1);
        check("t3b_sum", 64'(bus8.sum), 64'h01);
        check("t3b_cout", 64'(bus8.cout), 64'd0);

        // Start during RUN is ignored
        launch(1'b0, 8'h10, 8'h20, 1'b0);
        tick();
        tick();
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
        tick();
        bus8.start = 1'b0;
        wait_done(last_sum, 5);
        check("t4_sum", 64'(bus8.sum), 64'h30);
        check("t4_cout", 64'(bus8.cout), 64'd0);
        last_sum = bus8.sum;
        count_dones(12, nd);
        check("t4_no_second_done", 64'(nd), 64'd0);

        // Reset abandons an operation in flight
        launch(1'b0, 8'h33, 8'h11, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", 64'(bus8.busy), 64'd0);
        check("t5_done", 64'(bus8.done), 64'd0);
        check("t5_sum", 64'(bus8.sum), 64'd0);
        check("t5_cout", 64'(bus8.cout), 64'd0);
        count_dones(12, nd);
        check("t5_no_done", 64'(nd), 64'd0);
        last_sum = 8'h00;
        do_op(1'b0, 8'h01, 8'h01, 1'b0);
        check("t5b_sum", 64'(bus8.sum), 64'h02);

        // Back-to-back: start held so the DONE edge accepts the second op
        launch(1'b0, 8'h21, 8'h13, 1'b0);
        bus8.start = 1'b1; bus8.sub = 1'b1; bus8.a = 8'h40; bus8.b = 8'h41; bus8.cin = 1'b0;
        wait_done(last_sum, 8);
        check("t6_first_sum", 64'(bus8.sum), 64'h34);
        last_sum = bus8.sum;
        tick();
        bus8.start = 1'b0;
        check("t6_no_gap_busy", 64'(bus8.busy), 64'd1);
        wait_done(last_sum, 8);
        check("t6_second_sum", 64'(bus8.sum), 64'hFF);
        check("t6_second_cout", 64'(bus8.cout), 64'd1);
        last_sum = bus8.sum;
        tick();

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // WIDTH=1 build: full truth table
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            ref_op(1, v[3], 64'(v[2]), 64'(v[1]), v[0], es, ec);
            bus1.sub = v[3]; bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0];
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            check("w1_busy", 64'(bus1.busy), 64'd1);
            tick();
            check("w1_done", 64'(bus1.done), 64'd1);
            check("w1_sum", 64'(bus1.sum), es);
            check("w1_cout", 64'(bus1.cout), 64'(ec));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, parametrised add/subtract unit: the sequential successor to the single-bit combinational full adder.
- One full-adder cell plus a carry flip-flop processes a WIDTH-bit operand pair LSB-first, one bit per clock.
- Start/busy/done handshake; result held until the next accepted operation.
- Used where area matters more than latency: arithmetic in controllers and multi-word counters.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- sub  input  1  mode at accept: 0 = a+b+cin; 1 = a-b-cin (cin is borrow-in).
- a  input  WIDTH  operand A, sampled only at accept.
- b  input  WIDTH  operand B, sampled only at accept.
- cin  input  1  carry-in (add) or borrow-in (sub), sampled only at accept.
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  registered result; changes only on DONE entry or reset.
- cout  output  1  carry-out (add) or borrow-out (sub); same update rule as sum.

Behaviour:
- Reset: on any edge with rst=1, state=IDLE and busy=0, done=0, sum=0, cout=0. All internal shift registers, carry and counter are cleared. rst overrides start. An operation in progress is abandoned, with no done pulse.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Accept occurs when start=1 and state is IDLE or DONE:
  - load a_sr=a and b_sr=(sub ? ~b : b);
  - set carry=(sub ? ~cin : cin); count=0; latch mode; state=RUN.
- start while RUN is ignored, with no queuing.
- RUN, each edge:
  - fa_cell(a_sr[0], b_sr[0], carry) gives s, co;
  - shift s into res_sr from the MSB side;
  - right-shift a_sr and b_sr; carry=co; count=count+1;
  - when count reaches WIDTH-1 on this edge, go to DONE.
- DONE entry: sum=final res_sr and cout=(mode_sub ? ~carry : carry).
- Latency: if start is sampled at edge T, busy=1 after edges T..T+WIDTH-1, and done=1 plus the new sum/cout are visible after edge T+WIDTH, for exactly one cycle.
- DONE exits to RUN if start=1 that edge (back-to-back, sum still holds the old value until its own done), otherwise to IDLE.
- Arithmetic:
  - sum = (a + b + cin) mod 2^WIDTH;
  - for sub, sum = (a - b - cin) mod 2^WIDTH and cout=1 iff a < b+cin (unsigned borrow).
- Counter width is $clog2(WIDTH+1). WIDTH=1 gives a one-cycle RUN.
- Changes on a, b, cin or sub outside the accept edge have no effect.

Decomposition:
- Shared package adder_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, fa_cell: purely combinational 1-bit full adder, inputs x, y, ci and outputs s, co. It is instantiated once.
- The serial_adder top holds the FSM, counter, shift registers and result registers.

Test Plan:
1. WIDTH=8, add, a=8'h0F, b=8'h01, cin=0 -> done exactly 8 edges after the accept edge; sum=8'h10, cout=0; busy high 8 cycles.
2. Add a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=0, b=0, cin=1 -> sum=8'h01, cout=0.
3. Sub a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=1. Then a=8'h07, b=8'h05, cin=1 -> sum=8'h01, cout=0.
4. Accept 8'h10+8'h20, then pulse start with 8'hAA+8'h55 at RUN cycle 3 -> ignored; done yields sum=8'h30; no second done.
5. rst=1 at RUN cycle 3 -> next cycle busy=0, done=0, sum=0, cout=0 and no done pulse. A subsequent accept of 8'h01+8'h01 completes with sum=8'h02.
6. Back-to-back: start held through the done cycle -> second operation accepted with no idle gap; sum holds the first result until the second done. Plus a WIDTH=1 build covering all 16 combinations of (a, b, cin, sub), with sum/cout matching the truth table.
